// File: rtl/text_scanner.sv
// ---------------------------------------------------------------------------
// text_scanner
//
// Reader side of a text-mode framebuffer. Generates VGA timing from the pixel
// clock, issues character addresses to the framebuffer, looks up the glyph
// row in an external font ROM and serialises it to a 1-bit pixel stream.
//
// Pipeline (all outputs exactly 3 clk after the counter state they describe):
//   stage 0 : hcnt/vcnt, pos driven combinationally
//   stage 1 : char arrives, font_addr driven combinationally
//   stage 2 : font_data arrives, pixel bit selected and inverse applied
//   stage 3 : registered pixel / hsync / vsync / de / frame_start
//
// Ports:
//   clk         in   pixel clock
//   rst         in   asynchronous reset, active-high
//   pos         out  character address, row*COLS + col, 0 while blanking
//   char        in   framebuffer data, valid 1 clk after pos; [7] = inverse
//   font_addr   out  {char[6:0], glyph_row[3:0]}
//   font_data   in   glyph row, valid 1 clk after font_addr; bit 7 = leftmost
//   pixel       out  video bit (0 outside the visible region)
//   hsync       out  horizontal sync, active-low
//   vsync       out  vertical sync, active-high
//   de          out  display enable
//   frame_start out  1-clk pulse with the first visible pixel of a frame
// ---------------------------------------------------------------------------
module text_scanner #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 400,
    parameter int V_FRONT   = 12,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 35,
    parameter int COLS      = 80
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] pos,
    input  logic [7:0]  char,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic        pixel,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);

    localparam logic [HCW-1:0] H_ONE    = HCW'(1);
    localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_VIS_C  = HCW'(H_VISIBLE);
    localparam logic [HCW-1:0] HS_BEG_C = HCW'(H_VISIBLE + H_FRONT);
    localparam logic [HCW-1:0] HS_END_C = HCW'(H_VISIBLE + H_FRONT + H_SYNC);

    localparam logic [VCW-1:0] V_ONE    = VCW'(1);
    localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_VIS_C  = VCW'(V_VISIBLE);
    localparam logic [VCW-1:0] VS_BEG_C = VCW'(V_VISIBLE + V_FRONT);
    localparam logic [VCW-1:0] VS_END_C = VCW'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic [10:0]    COLS_C   = 11'(COLS);

    // ------------------------------------------------------------------
    // Stage 0: raster counters
    // ------------------------------------------------------------------
    logic [HCW-1:0] hcnt_q, hcnt_d;
    logic [VCW-1:0] vcnt_q, vcnt_d;

    // Next raster position: hcnt wraps at end of line, vcnt steps on the wrap.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            if (vcnt_q == V_LAST) begin
                vcnt_d = '0;
            end else begin
                vcnt_d = vcnt_q + V_ONE;
            end
        end else begin
            hcnt_d = hcnt_q + H_ONE;
            vcnt_d = vcnt_q;
        end
    end

    // Raster counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Stage-0 decode. Sync flags are kept as "inside pulse" (active-high) so
    // every pipeline register can reset to 0; hsync polarity is applied only
    // at the output register.
    logic        vis0_s;
    logic        hsp0_s;
    logic        vsp0_s;
    logic        fs0_s;
    logic [10:0] pos_s;

    // Visible-region, sync-window and frame-start decode plus char address.
    always_comb begin
        vis0_s = (hcnt_q < H_VIS_C) && (vcnt_q < V_VIS_C);
        hsp0_s = (hcnt_q >= HS_BEG_C) && (hcnt_q < HS_END_C);
        vsp0_s = (vcnt_q >= VS_BEG_C) && (vcnt_q < VS_END_C);
        fs0_s  = (hcnt_q == '0) && (vcnt_q == '0);
        // Each glyph is 8 px wide and 16 lines tall, so the character cell
        // is simply the counters with the low bits dropped.
        if (vis0_s) begin
            pos_s = (11'(vcnt_q >> 4) * COLS_C) + 11'(hcnt_q >> 3);
        end else begin
            pos_s = 11'd0;
        end
    end

    assign pos = pos_s;

    // ------------------------------------------------------------------
    // Stage 1: char is valid, drive the font ROM
    // ------------------------------------------------------------------
    logic       vis1_q;
    logic       hsp1_q;
    logic       vsp1_q;
    logic       fs1_q;
    logic [3:0] row1_q;
    logic [2:0] x1_q;

    // Stage-1 pipeline: glyph row and pixel column travel with the char fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vis1_q <= 1'b0;
            hsp1_q <= 1'b0;
            vsp1_q <= 1'b0;
            fs1_q  <= 1'b0;
            row1_q <= 4'd0;
            x1_q   <= 3'd0;
        end else begin
            vis1_q <= vis0_s;
            hsp1_q <= hsp0_s;
            vsp1_q <= vsp0_s;
            fs1_q  <= fs0_s;
            row1_q <= vcnt_q[3:0];
            x1_q   <= hcnt_q[2:0];
        end
    end

    assign font_addr = {char[6:0], row1_q};

    // ------------------------------------------------------------------
    // Stage 2: font_data is valid, pick the pixel bit
    // ------------------------------------------------------------------
    logic       vis2_q;
    logic       hsp2_q;
    logic       vsp2_q;
    logic       fs2_q;
    logic [2:0] x2_q;
    logic       inv2_q;

    // Stage-2 pipeline: inverse attribute is captured here so it lines up
    // with the ROM output rather than with the char that produced it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vis2_q <= 1'b0;
            hsp2_q <= 1'b0;
            vsp2_q <= 1'b0;
            fs2_q  <= 1'b0;
            x2_q   <= 3'd0;
            inv2_q <= 1'b0;
        end else begin
            vis2_q <= vis1_q;
            hsp2_q <= hsp1_q;
            vsp2_q <= vsp1_q;
            fs2_q  <= fs1_q;
            x2_q   <= x1_q;
            inv2_q <= char[7];
        end
    end

    logic bit2_s;
    logic pixel_d;

    // Bit 7 of the glyph row is the leftmost pixel; blanking forces 0 even
    // for inverse-video characters.
    always_comb begin
        bit2_s = font_data[3'd7 - x2_q] ^ inv2_q;
        if (vis2_q) begin
            pixel_d = bit2_s;
        end else begin
            pixel_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: output registers
    // ------------------------------------------------------------------
    logic pixel_q;
    logic hsync_q;
    logic vsync_q;
    logic de_q;
    logic fs_q;

    // Output registers; hsync idles high (active-low pulse).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_q <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b0;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            pixel_q <= pixel_d;
            hsync_q <= ~hsp2_q;
            vsync_q <= vsp2_q;
            de_q    <= vis2_q;
            fs_q    <= fs2_q;
        end
    end

    assign pixel       = pixel_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = fs_q;

    text_scanner_chk #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .pos   (pos_s),
        .hsync (hsync_q),
        .vsync (vsync_q)
    );

endmodule

// ---------------------------------------------------------------------------
// text_scanner_chk
//
// Property checker for text_scanner: character address range and sync
// periodicity. font_addr[3:0] < 16 holds by construction (4-bit field).
//
// Ports:
//   clk, rst  clock and asynchronous active-high reset of the scanner
//   pos       character address from the scanner
//   hsync     registered hsync (active-low)
//   vsync     registered vsync (active-high)
// ---------------------------------------------------------------------------
module text_scanner_chk #(
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 449
) (
    input logic        clk,
    input logic        rst,
    input logic [10:0] pos,
    input logic        hsync,
    input logic        vsync
);

    localparam logic [31:0] H_PER_C = 32'(H_TOTAL);
    localparam logic [31:0] V_PER_C = 32'(H_TOTAL * V_TOTAL);

    logic        hsync_prev_q;
    logic        vsync_prev_q;
    logic        hseen_q;
    logic        vseen_q;
    logic [31:0] hper_q;
    logic [31:0] vper_q;
    logic        hfall_s;
    logic        vrise_s;

    assign hfall_s = hsync_prev_q & ~hsync;
    assign vrise_s = ~vsync_prev_q & vsync;

    // Clock counts between successive sync leading edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_prev_q <= 1'b1;
            vsync_prev_q <= 1'b0;
            hseen_q      <= 1'b0;
            vseen_q      <= 1'b0;
            hper_q       <= 32'd0;
            vper_q       <= 32'd0;
        end else begin
            hsync_prev_q <= hsync;
            vsync_prev_q <= vsync;
            if (hfall_s) begin
                hseen_q <= 1'b1;
                hper_q  <= 32'd1;
            end else begin
                hper_q  <= hper_q + 32'd1;
            end
            if (vrise_s) begin
                vseen_q <= 1'b1;
                vper_q  <= 32'd1;
            end else begin
                vper_q  <= vper_q + 32'd1;
            end
        end
    end

    a_pos_range: assert property (@(posedge clk) disable iff (rst)
        pos < 11'd2000);

    a_hsync_period: assert property (@(posedge clk) disable iff (rst)
        (hfall_s && hseen_q) |-> (hper_q == H_PER_C));

    a_vsync_period: assert property (@(posedge clk) disable iff (rst)
        (vrise_s && vseen_q) |-> (vper_q == V_PER_C));

endmodule

// File: tb/tb_text_scanner.sv
// ---------------------------------------------------------------------------
// tb_text_scanner
//
// Directed bench for text_scanner. The vertical geometry is shortened
// (32 visible lines, 49 total) so that a whole frame plus a mid-frame reset
// fit in a short run; horizontal timing is the full 800-clock line.
// Framebuffer and font ROM are 1-cycle registered models. For every counter
// state the bench predicts the outputs and queues them; they are compared
// when they emerge three clocks later.
// ---------------------------------------------------------------------------
module tb_text_scanner;

    localparam int VV  = 32;
    localparam int VF  = 12;
    localparam int VSW = 2;
    localparam int VB  = 3;
    localparam int VT  = VV + VF + VSW + VB;
    localparam int HT  = 800;
    localparam logic [4:0] RST_V = 5'b01000; // pixel,hsync,vsync,de,fs

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] pos;
    logic [10:0] font_addr;
    logic [7:0]  char;
    logic [7:0]  font_data;
    logic        pixel;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        frame_start;

    logic [7:0]  fb_mem [0:1999];

    int checks = 0;
    int errors = 0;
    int rh, rv, cyc;
    int de_cnt, vs_cnt, hs_low_cnt, vs_first, fs_first, cap_idx;
    logic [7:0] pix_cap;
    logic [7:0] char_cap;
    logic [3:0] row_cap;
    logic [4:0] sb [$];

    text_scanner #(
        .V_VISIBLE (VV),
        .V_FRONT   (VF),
        .V_SYNC    (VSW),
        .V_BACK    (VB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pos         (pos),
        .char        (char),
        .font_addr   (font_addr),
        .font_data   (font_data),
        .pixel       (pixel),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .frame_start (frame_start)
    );

    always #20 clk = ~clk;

    function automatic logic [7:0] font_fn(input logic [10:0] a);
        if (a[10:4] == 7'h41) return 8'h18;
        return a[7:0] ^ {a[3:0], a[10:7]};
    endfunction

    // Framebuffer and font ROM, each one registered read.
    always @(posedge clk) begin
        char      <= fb_mem[pos];
        font_data <= font_fn(font_addr);
    end

    function automatic int exp_pos(input int h, input int v);
        if (h < 640 && v < VV) return (v / 16) * 80 + h / 8;
        return 0;
    endfunction

    task automatic check_reset(input string tag);
        checks++;
        assert ({pixel, hsync, vsync, de, frame_start} === RST_V) else begin
            errors++;
            $error("FAIL %s outputs got %b want %b", tag,
                   {pixel, hsync, vsync, de, frame_start}, RST_V);
        end
        checks++;
        assert (pos === 11'd0) else begin
            errors++;
            $error("FAIL %s pos got %0d want 0", tag, pos);
        end
    endtask

    task automatic start_run();
        rh = 0; rv = 0; cyc = 0;
        de_cnt = 0; vs_cnt = 0; hs_low_cnt = 0;
        vs_first = -1; fs_first = -1; cap_idx = 0; pix_cap = 8'h00;
        sb.delete();
        sb.push_back(RST_V);
        sb.push_back(RST_V);
    endtask

    task automatic tick();
        logic [4:0]  e;
        logic [7:0]  c;
        logic [7:0]  g;
        logic        vis;
        logic        pe;
        logic [10:0] p;
        vis = (rh < 640) && (rv < VV);
        p   = 11'(exp_pos(rh, rv));
        c   = fb_mem[p];
        g   = font_fn({c[6:0], 4'(rv)});
        pe  = vis ? (g[7 - (rh % 8)] ^ c[7]) : 1'b0;
        e   = {pe, !(rh >= 656 && rh < 752), (rv >= VV + VF && rv < VV + VF + VSW),
               vis, (rh == 0 && rv == 0)};
        sb.push_back(e);
        char_cap = c;
        row_cap  = 4'(rv);
        @(posedge clk);
        #1;
        if (rh == HT - 1) begin
            rh = 0;
            rv = (rv == VT - 1) ? 0 : rv + 1;
        end else begin
            rh = rh + 1;
        end
        cyc++;
        e = sb.pop_front();
        checks++;
        assert ({pixel, hsync, vsync, de, frame_start} === e) else begin
            errors++;
            $error("FAIL outputs cyc %0d got %b want %b", cyc,
                   {pixel, hsync, vsync, de, frame_start}, e);
        end
        checks++;
        assert (pos === 11'(exp_pos(rh, rv))) else begin
            errors++;
            $error("FAIL pos h=%0d v=%0d got %0d want %0d", rh, rv, pos, exp_pos(rh, rv));
        end
        checks++;
        assert (font_addr === {char_cap[6:0], row_cap}) else begin
            errors++;
            $error("FAIL font_addr cyc %0d got %h want %h", cyc, font_addr,
                   {char_cap[6:0], row_cap});
        end
        if (de) de_cnt++;
        if (vsync) vs_cnt++;
        if (!hsync) hs_low_cnt++;
        if (vsync && vs_first < 0) vs_first = cyc;
        if (frame_start && fs_first < 0) fs_first = cyc;
        if (de && cap_idx < 8) begin
            pix_cap[7 - cap_idx] = pixel;
            cap_idx++;
        end
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        checks++;
        assert (got == want) else begin
            errors++;
            $error("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    initial begin
        for (int i = 0; i < 2000; i++) fb_mem[i] = 8'(i * 37 + 5);
        fb_mem[0] = 8'h41;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_reset("reset_hold");
        end
        @(negedge clk);
        rst = 1'b0;
        start_run();

        // Frame 1: plain "A" at pos 0; switch to inverse "A" in vertical blank.
        repeat ((VV + 1) * HT) tick();
        check_int("pix_pattern_A", int'(pix_cap), 32'h18);
        check_int("first_frame_start", fs_first, 3);
        fb_mem[0] = 8'hC1;
        repeat ((VT - VV - 1) * HT) tick();
        check_int("vsync_first_rise", vs_first, (VV + VF) * HT + 3);
        check_int("vsync_high_clks", vs_cnt, VSW * HT);
        check_int("de_high_clks", de_cnt, 640 * VV);
        check_int("hsync_low_clks", hs_low_cnt, 96 * VT);

        // Frame 2: inverse "A", run to hcnt=300 vcnt=20 then reset.
        cap_idx = 0;
        repeat (20 * HT + 300) tick();
        check_int("pix_pattern_invA", int'(pix_cap), 32'hE7);
        rst = 1'b1;
        #1;
        check_reset("async_reset");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_reset("reset_mid_hold");
        end
        @(negedge clk);
        rst = 1'b0;
        start_run();
        checks++;
        assert (pos === 11'd0) else begin
            errors++;
            $error("FAIL pos_after_reset got %0d want 0", pos);
        end
        repeat (3) tick();
        check_int("frame_start_after_reset", fs_first, 3);
        checks++;
        assert ((frame_start === 1'b1) && (de === 1'b1)) else begin
            errors++;
            $error("FAIL fs_de_after_reset got fs=%b de=%b want 1 1", frame_start, de);
        end
        repeat (2 * HT) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
